// File: rtl/fc_backprop_engine.sv
// fc_backprop_engine
//   Backpropagation engine for one fully connected layer. The host loads
//   activations, weights and output deltas through a banked register port,
//   pulses start, and the engine walks every (o,i) weight once: it
//   accumulates the propagated error err[i] from the old weight, applies
//   the gradient step to the weight, then streams err[] out over a
//   valid/ready channel and pulses done.
//   Optional build macro FC_BP_SAT_EN: saturate err accumulation and weight
//   update results instead of wrapping modulo 2^DATA_W.
module fc_backprop_engine #(
    parameter int unsigned IN_CELL  = 32,
    parameter int unsigned OUT_CELL = 20,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned FRAC_W   = 10,
    parameter int unsigned LR_SHIFT = 5,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [1:0]        bank,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              start,
    output logic              busy,
    output logic              err_valid,
    input  logic              err_ready,
    output logic [DATA_W-1:0] err_data,
    output logic [ADDR_W-1:0] err_addr,
    output logic              done
);

    localparam int unsigned NW = IN_CELL * OUT_CELL;
    localparam int unsigned IW = (IN_CELL  > 1) ? $clog2(IN_CELL)  : 1;
    localparam int unsigned OW = (OUT_CELL > 1) ? $clog2(OUT_CELL) : 1;
    localparam int unsigned WW = (NW > 1)       ? $clog2(NW)       : 1;
    // Wide enough for a full product plus one add/subtract without overflow
    localparam int unsigned SW = 2 * DATA_W + 2;

    localparam logic [IW-1:0]     I_LAST = IW'(IN_CELL - 1);
    localparam logic [OW-1:0]     O_LAST = OW'(OUT_CELL - 1);
    localparam logic [ADDR_W-1:0] E_LAST = ADDR_W'(IN_CELL - 1);

`ifdef FC_BP_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       i_q;
    logic [OW-1:0]       o_q;
    logic [WW-1:0]       widx_q;
    logic [ADDR_W-1:0]   err_addr_q;
    logic [DATA_W-1:0]   rdata_q;

    logic signed [DATA_W-1:0] act_mem   [IN_CELL];
    logic signed [DATA_W-1:0] w_mem     [NW];
    logic signed [DATA_W-1:0] delta_mem [OUT_CELL];
    logic signed [DATA_W-1:0] err_mem   [IN_CELL];

    logic signed [DATA_W-1:0] w_old, dlt, act_v, err_v, err_d, w_d;
    logic signed [SW-1:0]     prod_wd, prod_ad, err_base, err_sum, w_dif;
    logic                     addr_ok, host_wr;
    logic [DATA_W-1:0]        rd_word;

    // Reduce a wide signed result to DATA_W bits (clamp or wrap)
    function automatic logic signed [DATA_W-1:0] fit(input logic signed [SW-1:0] v);
`ifdef FC_BP_SAT_EN
        if (v > SAT_MAX)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return DATA_W'(v);
`else
        return DATA_W'(v);
`endif
    endfunction

    // Per-pair datapath: error accumulation from the old weight and gradient step
    always_comb begin
        w_old    = w_mem[widx_q];
        dlt      = delta_mem[o_q];
        act_v    = act_mem[i_q];
        err_v    = err_mem[i_q];
        prod_wd  = (SW'(w_old) * SW'(dlt)) >>> FRAC_W;
        prod_ad  = (SW'(act_v) * SW'(dlt)) >>> FRAC_W;
        err_base = (o_q == '0) ? '0 : SW'(err_v);
        err_sum  = err_base + prod_wd;
        w_dif    = SW'(w_old) - (prod_ad >>> LR_SHIFT);
        err_d    = fit(err_sum);
        w_d      = fit(w_dif);
    end

    // Host address decode: range check and read mux
    always_comb begin
        addr_ok = 1'b0;
        rd_word = '0;
        case (bank)
            2'd0: begin
                addr_ok = (addr < ADDR_W'(IN_CELL));
                if (addr_ok) rd_word = act_mem[addr[IW-1:0]];
            end
            2'd1: begin
                addr_ok = (addr < ADDR_W'(NW));
                if (addr_ok) rd_word = w_mem[addr[WW-1:0]];
            end
            2'd2: begin
                addr_ok = (addr < ADDR_W'(OUT_CELL));
                if (addr_ok) rd_word = delta_mem[addr[OW-1:0]];
            end
            default: begin
                addr_ok = (addr < ADDR_W'(IN_CELL));
                if (addr_ok) rd_word = err_mem[addr[IW-1:0]];
            end
        endcase
    end

    assign host_wr = we && (state_q == IDLE) && addr_ok && (bank != 2'd3);

    // Bank storage: host writes while idle, engine read-modify-write in UPDATE; never cleared by reset
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (host_wr) begin
                case (bank)
                    2'd0:    act_mem[addr[IW-1:0]]   <= wdata;
                    2'd1:    w_mem[addr[WW-1:0]]     <= wdata;
                    2'd2:    delta_mem[addr[OW-1:0]] <= wdata;
                    default: ;
                endcase
            end else if (state_q == UPDATE) begin
                err_mem[i_q]  <= err_d;
                w_mem[widx_q] <= w_d;
            end
        end
    end

    // Registered host read data
    always_ff @(posedge clk) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rd_word;
    end

    // Control FSM: pair walk in UPDATE, beat index in STREAM
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            i_q        <= '0;
            o_q        <= '0;
            widx_q     <= '0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= UPDATE;
                        i_q     <= '0;
                        o_q     <= '0;
                        widx_q  <= '0;
                    end
                end
                UPDATE: begin
                    widx_q <= widx_q + 1'b1;
                    if (i_q == I_LAST) begin
                        i_q <= '0;
                        if (o_q == O_LAST) begin
                            state_q    <= STREAM;
                            o_q        <= '0;
                            widx_q     <= '0;
                            err_addr_q <= '0;
                        end else begin
                            o_q <= o_q + 1'b1;
                        end
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                STREAM: begin
                    if (err_ready) begin
                        if (err_addr_q == E_LAST) state_q <= DONE;
                        else                      err_addr_q <= err_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign err_valid = (state_q == STREAM);
    assign done      = (state_q == DONE);
    assign err_addr  = err_addr_q;
    // err_mem is not written outside UPDATE, so the beat holds while stalled
    assign err_data  = err_valid ? err_mem[err_addr_q[IW-1:0]] : '0;
    assign rdata     = rdata_q;

endmodule

// File: doc/fc_backprop_engine.md
FC_BACKPROP_ENGINE -- requirements
Module: fc_backprop_engine

Interface
REQ-001 SHALL have parameter IN_CELL, default 32, number of input cells (activations / propagated errors).
REQ-002 SHALL have parameter OUT_CELL, default 20, number of output cells (incoming deltas).
REQ-003 SHALL have parameter DATA_W, default 16, signed two's-complement data width.
REQ-004 SHALL have parameter FRAC_W, default 10, fixed-point fraction bits.
REQ-005 SHALL have parameter LR_SHIFT, default 5, learning rate as a right-shift (rate = 2^-LR_SHIFT).
REQ-006 SHALL have parameter ADDR_W, default 16, host address width, at least clog2(IN_CELL*OUT_CELL).
REQ-007 Ports, in this order:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- we  in  1  host write strobe.
- bank  in  2  host bank select: 0 = act, 1 = weight, 2 = delta, 3 = err (read-only).
- addr  in  ADDR_W  host address; weight address = o*IN_CELL+i.
- wdata  in  DATA_W  host write data.
- rdata  out  DATA_W  host read data, registered.
- start  in  1  one-cycle request to run backprop.
- busy  out  1  engine not IDLE.
- err_valid  out  1  streamed error beat valid.
- err_ready  in  1  downstream accepts beat.
- err_data  out  DATA_W  propagated error err[i].
- err_addr  out  ADDR_W  index i of err_data.
- done  out  1  one-cycle completion pulse.

Function
REQ-008 Bank storage SHALL be: act[IN_CELL], weight[OUT_CELL*IN_CELL], delta[OUT_CELL], err[IN_CELL].
REQ-009 Host write SHALL occur only when we=1 and busy=0; writes with busy=1, writes to bank 3, and out-of-range addresses SHALL be ignored.
REQ-010 rdata SHALL equal the addressed word one cycle after addr/bank are presented; out-of-range reads return 0.
REQ-011 fmul(a,b) SHALL be the full 2*DATA_W signed product, arithmetic-shifted right by FRAC_W.
REQ-012 FSM states: IDLE, UPDATE, STREAM, DONE.
REQ-013 IDLE->UPDATE on start=1; start outside IDLE SHALL be ignored; busy=1 from the next cycle.
REQ-014 UPDATE SHALL visit one (o,i) pair per cycle, i fastest, o from 0 to OUT_CELL-1, taking exactly OUT_CELL*IN_CELL cycles.
REQ-015 Per pair: err[i] = (o==0 ? 0 : err[i]) + fmul(w_old[o][i], delta[o]), using the pre-update weight.
REQ-016 Per pair: w[o][i] = w_old[o][i] - (fmul(act[i], delta[o]) >>> LR_SHIFT).
REQ-017 UPDATE->STREAM after the last pair; STREAM SHALL present err[0..IN_CELL-1] in order with err_valid=1.
REQ-018 A beat SHALL advance only on err_valid & err_ready; while err_ready=0, err_data/err_addr SHALL hold stable.
REQ-019 After the last beat is accepted, STREAM->DONE; DONE SHALL assert done for one cycle, then go to IDLE.
REQ-020 err_valid, done, busy SHALL be combinationally consistent with state: err_valid only in STREAM, done only in DONE.

Reset
REQ-021 On clk edge with reset_n=0: state=IDLE, busy=0, err_valid=0, done=0, err_data=0, err_addr=0, rdata=0, counters=0.
REQ-022 Memory contents SHALL NOT be altered by reset; reset mid-UPDATE leaves partially updated weights/err as-is.
REQ-023 Reset SHALL take priority over start, we and err_ready in the same cycle.

Configuration
REQ-024 Macro FC_BP_SAT_EN: when defined, every err accumulation and weight subtraction SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; when undefined, results SHALL wrap modulo 2^DATA_W.

Verification (IN_CELL=4, OUT_CELL=2, DATA_W=16, FRAC_W=10, LR_SHIFT=5)
REQ-025 act=1024 all, weight=512 all, delta={1024,0}, start -> UPDATE 8 cycles; err={512,512,512,512}; w[0][*]=480, w[1][*]=512.
REQ-026 Same run, err_ready=0 for 3 cycles on beat 1 -> err_addr=1, err_data=512 held 3 cycles; done pulses once, 1 cycle after beat 3 accepted.
REQ-027 w[0][0]=-32760, act[0]=32767, delta[0]=1024 -> w[0][0]=-32768 with FC_BP_SAT_EN; 31753 without.
REQ-028 start and we (bank 1, addr 0, 7) during UPDATE -> no restart, w[0][0] unaffected by host write.
REQ-029 reset_n=0 at UPDATE cycle 3 -> next cycle busy=0, err_valid=0, done=0; new start completes normally.
